// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_RR,
    ST_LOCK,
    ST_BREAK
  } arb_state_e;

  localparam int BRAM_ADDR_W = 32;
  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_WE_W   = 4;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Read-return tag pipeline: tracks which requester owns each in-flight BRAM read.
module mem_arb_tagpipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

  // Shift toward the MSB; the MSB is the stage whose data is on bram_rdata now.
  assign vld_d = (vld_q << 1) | RD_LAT'(valid_i);
  assign own_d = (own_q << 1) | RD_LAT'(owner_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign valid_o = vld_q[RD_LAT-1];
  assign owner_o = own_q[RD_LAT-1];

endmodule

// File: rtl/mem_arb.sv
// Two-requester BRAM arbiter: round-robin with an m1 lock that m0 can break
// after LOCK_MAX cycles, plus read-data return routing.
//
//   state    | meaning
//   ST_RR    | round-robin between m0 and m1
//   ST_LOCK  | m1 owns the port back-to-back, m0 held off
//   ST_BREAK | one forced m0 slot after the lock hit LOCK_MAX
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [DATA_W-1:0]      m0_wdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [DATA_W-1:0]      m1_wdata,
  input  logic                   m1_lock,
  output logic                   m0_gnt,
  output logic                   m1_gnt,
  output logic                   m0_rvalid,
  output logic                   m1_rvalid,
  output logic [DATA_W-1:0]      m0_rdata,
  output logic [DATA_W-1:0]      m1_rdata,
  output logic                   bram_en,
  output logic [BRAM_WE_W-1:0]   bram_web,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [BRAM_DATA_W-1:0] bram_wdata,
  input  logic [BRAM_DATA_W-1:0] bram_rdata,
  output logic                   lock_forced
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic             sel_m1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RR;
      last_q   <= ID_M1;
      cnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
    end
  end

  // The cycle that acquires the lock counts as the first held cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    sel_m1   = 1'b0;
    unique case (state_q)
      ST_RR: begin
        sel_m1 = (m0_req && m1_req) ? (last_q == ID_M0) : m1_req;
        if (sel_m1 && m1_lock) begin
          state_d = ST_LOCK;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_LOCK: begin
        sel_m1 = 1'b1;
        if (!m1_lock) begin
          state_d = ST_RR;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          if (m0_req) begin
            state_d  = ST_BREAK;
            cnt_d    = '0;
            forced_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        sel_m1  = !m0_req;
        state_d = m1_lock ? ST_LOCK : ST_RR;
        cnt_d   = '0;
      end
      default: state_d = ST_RR;
    endcase
  end

  logic              gnt_any, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  assign m0_gnt  = m0_req & ~sel_m1 & ~reset;
  assign m1_gnt  = m1_req &  sel_m1 & ~reset;
  assign gnt_any = m0_gnt | m1_gnt;
  assign last_d  = gnt_any ? m1_gnt : last_q;

  assign g_we    = gnt_any & (m1_gnt ? m1_we : m0_we);
  assign g_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign g_wdata = m1_gnt ? m1_wdata : m0_wdata;

  assign bram_en     = gnt_any;
  assign bram_web    = {{(BRAM_WE_W-1){1'b0}}, g_we};
  assign bram_addr   = gnt_any ? BRAM_ADDR_W'(g_addr) : '0;
  assign bram_wdata  = g_we ? BRAM_DATA_W'(g_wdata) : '0;
  assign lock_forced = forced_q;

  logic rd_vld, rd_own;

  mem_arb_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (gnt_any & ~g_we),
    .owner_i (m1_gnt),
    .valid_o (rd_vld),
    .owner_o (rd_own)
  );

  assign m0_rvalid = rd_vld & (rd_own == ID_M0);
  assign m1_rvalid = rd_vld & (rd_own == ID_M1);
  assign m0_rdata  = m0_rvalid ? bram_rdata[DATA_W-1:0] : '0;
  assign m1_rdata  = m1_rvalid ? bram_rdata[DATA_W-1:0] : '0;

  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bram_rdata[BRAM_DATA_W-1:DATA_W];

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one RD_LAT=1 and one RD_LAT=3 instance on shared
// stimulus, with a write-first BRAM model whose unwritten words read as their address.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [11:0] m0_addr = '0, m1_addr = '0;
  logic [3:0]  m0_wdata = '0, m1_wdata = '0;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en, lock_forced;
  logic [3:0]  m0_rdata, m1_rdata, bram_web;
  logic [31:0] bram_addr, bram_wdata;

  logic        t3_m0_gnt_unused, t3_m1_gnt_unused, t3_m0_rvalid, t3_m1_rvalid;
  logic        t3_en_unused, t3_forced_unused;
  logic [3:0]  t3_m0_rdata, t3_m1_rdata, t3_web_unused;
  logic [31:0] t3_addr_unused, t3_wdata_unused;

  logic [31:0] mem [0:4095];
  logic [31:0] rdp [0:2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arb #(.RD_LAT(1)) u0 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_web(bram_web), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(rdp[0]), .lock_forced(lock_forced)
  );

  mem_arb #(.RD_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(t3_m0_gnt_unused), .m1_gnt(t3_m1_gnt_unused),
    .m0_rvalid(t3_m0_rvalid), .m1_rvalid(t3_m1_rvalid),
    .m0_rdata(t3_m0_rdata), .m1_rdata(t3_m1_rdata),
    .bram_en(t3_en_unused), .bram_web(t3_web_unused), .bram_addr(t3_addr_unused),
    .bram_wdata(t3_wdata_unused), .bram_rdata(rdp[2]), .lock_forced(t3_forced_unused)
  );

  // Both instances see identical requests, so one BRAM port drives both read pipes.
  initial for (int i = 0; i < 4096; i++) mem[i] <= 32'(i);

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_web[0]) mem[bram_addr[11:0]] <= bram_wdata;
      rdp[0] <= bram_web[0] ? bram_wdata : mem[bram_addr[11:0]];
    end
    rdp[1] <= rdp[0];
    rdp[2] <= rdp[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [3:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [3:0] d1,
                       input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    m1_lock = lk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h0, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0);
  endtask

  initial begin
    // Requests held high during reset must not leak through.
    drive(1'b1, 1'b0, 12'h003, 4'h0, 1'b1, 1'b0, 12'h00C, 4'h0, 1'b0);
    tick(); mid();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_lock_forced", lock_forced, 0);
    tick(); idle(); reset = 1'b0;

    // Simultaneous reads: m0,m1,m0,m1, each returning one cycle later.
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) drive(1'b1, 1'b0, 12'h003, 4'h0, 1'b1, 1'b0, 12'h00C, 4'h0, 1'b0);
      else idle();
      mid();
      check($sformatf("rr_m0_gnt[%0d]", i), m0_gnt, 32'(i < 4 && i % 2 == 0));
      check($sformatf("rr_m1_gnt[%0d]", i), m1_gnt, 32'(i < 4 && i % 2 == 1));
      check($sformatf("rr_m0_rvalid[%0d]", i), m0_rvalid, 32'(i == 1 || i == 3));
      check($sformatf("rr_m1_rvalid[%0d]", i), m1_rvalid, 32'(i == 2 || i == 4));
      check($sformatf("rr_m0_rdata[%0d]", i), m0_rdata, (i == 1 || i == 3) ? 32'h3 : 32'h0);
      check($sformatf("rr_m1_rdata[%0d]", i), m1_rdata, (i == 2 || i == 4) ? 32'hC : 32'h0);
    end
    for (int i = 0; i < 3; i++) tick();

    // m1 write with m0 idle.
    tick(); drive(1'b0, 1'b0, 12'h0, 4'h0, 1'b1, 1'b1, 12'h123, 4'hA, 1'b0); mid();
    check("wr_m1_gnt", m1_gnt, 1);
    check("wr_m0_gnt", m0_gnt, 0);
    check("wr_bram_en", bram_en, 1);
    check("wr_bram_web", bram_web, 32'h1);
    check("wr_bram_addr", bram_addr, 32'h123);
    check("wr_bram_wdata", bram_wdata, 32'hA);
    check("wr_m1_rvalid", m1_rvalid, 0);
    tick(); idle(); mid();
    check("wr_next_m1_rvalid", m1_rvalid, 0);
    check("idle_bram_en", bram_en, 0);
    check("idle_bram_web", bram_web, 0);
    check("idle_bram_addr", bram_addr, 0);
    check("idle_bram_wdata", bram_wdata, 0);

    // Write then immediate read of the same address.
    tick(); drive(1'b1, 1'b1, 12'h010, 4'h5, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0); mid();
    check("wf_wr_gnt", m0_gnt, 1);
    check("wf_wr_web", bram_web, 32'h1);
    tick(); drive(1'b1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0); mid();
    check("wf_rd_web", bram_web, 0);
    check("wf_rd_wdata", bram_wdata, 0);
    check("wf_rd_addr", bram_addr, 32'h010);
    tick(); idle(); mid();
    check("wf_rvalid", m0_rvalid, 1);
    check("wf_rdata", m0_rdata, 32'h5);
    check("wf_m1_rvalid", m1_rvalid, 0);
    for (int i = 0; i < 3; i++) tick();

    // RD_LAT=3 instance: reads m0,m1,m0 at cycles 0..2 return at 3,4,5.
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0)      drive(1'b1, 1'b0, 12'h003, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0);
      else if (i == 1) drive(1'b0, 1'b0, 12'h0, 4'h0, 1'b1, 1'b0, 12'h00C, 4'h0, 1'b0);
      else if (i == 2) drive(1'b1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0);
      else idle();
      mid();
      check($sformatf("lat3_m0_rvalid[%0d]", i), t3_m0_rvalid, 32'(i == 3 || i == 5));
      check($sformatf("lat3_m1_rvalid[%0d]", i), t3_m1_rvalid, 32'(i == 4));
      check($sformatf("lat3_m0_rdata[%0d]", i), t3_m0_rdata,
            (i == 3) ? 32'h3 : (i == 5) ? 32'h5 : 32'h0);
      check($sformatf("lat3_m1_rdata[%0d]", i), t3_m1_rdata, (i == 4) ? 32'hC : 32'h0);
    end

    // Lock acquired at cycle 0; m0 waits from cycle 10 and gets exactly cycle 64.
    for (int c = 0; c < 100; c++) begin
      tick(); drive(c >= 10, 1'b0, 12'h001, 4'h0, 1'b1, 1'b0, 12'h002, 4'h0, 1'b1); mid();
      check($sformatf("lock_m0_gnt[%0d]", c), m0_gnt, 32'(c == 64));
      check($sformatf("lock_m1_gnt[%0d]", c), m1_gnt, 32'(c != 64));
      check($sformatf("lock_forced[%0d]", c), lock_forced, 32'(c == 64));
    end
    tick(); idle();
    for (int i = 0; i < 3; i++) tick();

    // Counter saturates while m0 is idle; a late m0 request breaks in the next cycle.
    for (int c = 0; c < 73; c++) begin
      tick(); drive(c >= 70, 1'b0, 12'h001, 4'h0, 1'b1, 1'b0, 12'h002, 4'h0, 1'b1); mid();
      check($sformatf("sat_m0_gnt[%0d]", c), m0_gnt, 32'(c == 71));
      check($sformatf("sat_m1_gnt[%0d]", c), m1_gnt, 32'(c != 71));
    end
    tick(); idle();
    for (int i = 0; i < 3; i++) tick();

    // Reset the cycle after a read grant drops it; pointer returns to m0-first.
    tick(); drive(1'b1, 1'b0, 12'h003, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0); mid();
    check("rr_pre_rst_gnt", m0_gnt, 1);
    tick(); reset = 1'b1; idle(); mid();
    check("midrst_m0_rvalid", m0_rvalid, 0);
    check("midrst_bram_en", bram_en, 0);
    tick(); mid();
    check("midrst_lat3_rvalid", t3_m0_rvalid, 0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("postrst_m0_rvalid[%0d]", i), m0_rvalid, 0);
      check($sformatf("postrst_lat3_rvalid[%0d]", i), t3_m0_rvalid, 0);
      tick();
    end
    drive(1'b1, 1'b0, 12'h003, 4'h0, 1'b1, 1'b0, 12'h00C, 4'h0, 1'b0); mid();
    check("postrst_tie_m0_gnt", m0_gnt, 1);
    check("postrst_tie_m1_gnt", m1_gnt, 0);
    tick(); idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
